// File: rtl/ysyx_23060061_decode_stage.sv
// ysyx_23060061_decode_stage: RV32I decoder feeding a small output FIFO.
// Each instruction accepted from fetch is decoded combinationally and stored,
// together with its pc, as one FIFO entry. The head entry drives the execute
// side.
// Optional feature: define YSYX_23060061_RV32M_EN to decode the M extension
// (funct7 = 0000001 on OP). Without it those encodings decode as illegal.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready = !full (and 0 until the first edge after reset);
// out_valid = !empty. A push never happens while full, even if a pop happens
// in the same cycle. flush empties the FIFO on the edge and blocks that
// cycle's push and pop. While out_valid && !out_ready the outputs hold.
module ysyx_23060061_decode_stage #(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_instType,
  output logic            out_RegWrite,
  output logic [1:0]      out_MemRW,
  output logic [2:0]      out_MemWidth,
  output logic            out_aluAsel,
  output logic            out_aluBsel,
  output logic [1:0]      out_WBSel,
  output logic [4:0]      out_aluOp,
  output logic [2:0]      out_BrType,
  output logic            out_isBranch,
  output logic            out_isJump,
  output logic            out_BrUn,
  output logic            out_ebreak,
  output logic            out_illegal
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Instruction format codes shared with the rest of the core
  localparam logic [2:0] TYPE_R = 3'd0;
  localparam logic [2:0] TYPE_I = 3'd1;
  localparam logic [2:0] TYPE_S = 3'd2;
  localparam logic [2:0] TYPE_B = 3'd3;
  localparam logic [2:0] TYPE_U = 3'd4;
  localparam logic [2:0] TYPE_J = 3'd5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_PASSB = 5'd1;
  localparam logic [4:0] ALU_ADDCL = 5'd2;
  localparam logic [4:0] ALU_SUB   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_SLT   = 5'd5;
  localparam logic [4:0] ALU_XOR   = 5'd6;
  localparam logic [4:0] ALU_OR    = 5'd7;
  localparam logic [4:0] ALU_AND   = 5'd8;
  localparam logic [4:0] ALU_SLL   = 5'd9;
  localparam logic [4:0] ALU_SRL   = 5'd10;
  localparam logic [4:0] ALU_SRA   = 5'd11;

  // WBSel: 00 alu, 01 mul/div unit, 10 pc+4, 11 memory
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_MEM = 2'b11;

  typedef struct packed {
    logic [2:0] instType;
    logic       RegWrite;
    logic [1:0] MemRW;
    logic [2:0] MemWidth;
    logic       aluAsel;
    logic       aluBsel;
    logic [1:0] WBSel;
    logic [4:0] aluOp;
    logic [2:0] BrType;
    logic       isBranch;
    logic       isJump;
    logic       BrUn;
    logic       ebreak;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    ctrl_t           ctrl;
  } entry_t;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  ctrl_t           w_ctrl;
  logic            w_bad;
  logic [31:0]     w_imm32;
  entry_t          w_entry;
  entry_t          w_out;
  logic            w_full;
  logic            w_push;
  logic            w_pop;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_live;
  entry_t           r_mem [BUF_DEPTH];

  assign w_opcode = in_inst[6:0];
  assign w_funct3 = in_inst[14:12];
  assign w_funct7 = in_inst[31:25];

  // Control decode; any unrecognised encoding collapses to a bare illegal flag
  always_comb begin
    w_ctrl = '0;
    w_bad  = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_ctrl.instType = TYPE_U;
        w_ctrl.RegWrite = 1'b1;
        w_ctrl.aluBsel  = 1'b1;
        w_ctrl.aluOp    = ALU_PASSB;
      end
      OPC_AUIPC: begin
        w_ctrl.instType = TYPE_U;
        w_ctrl.RegWrite = 1'b1;
        w_ctrl.aluAsel  = 1'b1;
        w_ctrl.aluBsel  = 1'b1;
      end
      OPC_JAL: begin
        w_ctrl.instType = TYPE_J;
        w_ctrl.RegWrite = 1'b1;
        w_ctrl.isJump   = 1'b1;
        w_ctrl.WBSel    = WB_PC4;
        w_ctrl.aluAsel  = 1'b1;
        w_ctrl.aluBsel  = 1'b1;
      end
      OPC_JALR: begin
        if (w_funct3 == 3'b000) begin
          w_ctrl.instType = TYPE_I;
          w_ctrl.RegWrite = 1'b1;
          w_ctrl.isJump   = 1'b1;
          w_ctrl.WBSel    = WB_PC4;
          w_ctrl.aluBsel  = 1'b1;
          w_ctrl.aluOp    = ALU_ADDCL;
        end else begin
          w_bad = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (w_funct3 == 3'b010 || w_funct3 == 3'b011) begin
          w_bad = 1'b1;
        end else begin
          // The ALU forms the target pc+imm; the compare happens downstream
          w_ctrl.instType = TYPE_B;
          w_ctrl.isBranch = 1'b1;
          w_ctrl.BrType   = w_funct3;
          w_ctrl.BrUn     = w_funct3[2] & w_funct3[1];
          w_ctrl.aluAsel  = 1'b1;
          w_ctrl.aluBsel  = 1'b1;
        end
      end
      OPC_LOAD: begin
        case (w_funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: begin
            w_ctrl.instType = TYPE_I;
            w_ctrl.RegWrite = 1'b1;
            w_ctrl.MemRW    = 2'b10;
            w_ctrl.MemWidth = w_funct3;
            w_ctrl.WBSel    = WB_MEM;
            w_ctrl.aluBsel  = 1'b1;
          end
          default: w_bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        if (w_funct3[2] == 1'b0 && w_funct3 != 3'b011) begin
          w_ctrl.instType = TYPE_S;
          w_ctrl.MemRW    = 2'b01;
          w_ctrl.MemWidth = w_funct3;
          w_ctrl.aluBsel  = 1'b1;
        end else begin
          w_bad = 1'b1;
        end
      end
      OPC_OPIMM: begin
        w_ctrl.instType = TYPE_I;
        w_ctrl.RegWrite = 1'b1;
        w_ctrl.aluBsel  = 1'b1;
        case (w_funct3)
          3'b000: w_ctrl.aluOp = ALU_ADD;
          3'b010: w_ctrl.aluOp = ALU_SLT;
          3'b011: w_ctrl.aluOp = ALU_SLTU;
          3'b100: w_ctrl.aluOp = ALU_XOR;
          3'b110: w_ctrl.aluOp = ALU_OR;
          3'b111: w_ctrl.aluOp = ALU_AND;
          3'b001: begin
            if (w_funct7 == 7'b0000000) w_ctrl.aluOp = ALU_SLL;
            else                        w_bad = 1'b1;
          end
          default: begin
            if (w_funct7 == 7'b0000000)      w_ctrl.aluOp = ALU_SRL;
            else if (w_funct7 == 7'b0100000) w_ctrl.aluOp = ALU_SRA;
            else                             w_bad = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        w_ctrl.instType = TYPE_R;
        w_ctrl.RegWrite = 1'b1;
        case (w_funct7)
          7'b0000000: begin
            case (w_funct3)
              3'b000:  w_ctrl.aluOp = ALU_ADD;
              3'b001:  w_ctrl.aluOp = ALU_SLL;
              3'b010:  w_ctrl.aluOp = ALU_SLT;
              3'b011:  w_ctrl.aluOp = ALU_SLTU;
              3'b100:  w_ctrl.aluOp = ALU_XOR;
              3'b101:  w_ctrl.aluOp = ALU_SRL;
              3'b110:  w_ctrl.aluOp = ALU_OR;
              default: w_ctrl.aluOp = ALU_AND;
            endcase
          end
          7'b0100000: begin
            if (w_funct3 == 3'b000)      w_ctrl.aluOp = ALU_SUB;
            else if (w_funct3 == 3'b101) w_ctrl.aluOp = ALU_SRA;
            else                         w_bad = 1'b1;
          end
`ifdef YSYX_23060061_RV32M_EN
          7'b0000001: begin
            // mul..remu map onto 12..19 in funct3 order
            w_ctrl.aluOp = 5'd12 + {2'b00, w_funct3};
            w_ctrl.WBSel = 2'b01;
          end
`endif
          default: w_bad = 1'b1;
        endcase
      end
      OPC_FENCE: begin
        // Single-hart in-order core: fence has nothing to order
        if (w_funct3 == 3'b000) w_ctrl.instType = TYPE_I;
        else                    w_bad = 1'b1;
      end
      OPC_SYSTEM: begin
        if (in_inst == 32'h0000_0073) begin
          w_ctrl.instType = TYPE_I;
        end else if (in_inst == 32'h0010_0073) begin
          w_ctrl.instType = TYPE_I;
          w_ctrl.ebreak   = 1'b1;
        end else begin
          w_bad = 1'b1;
        end
      end
      default: w_bad = 1'b1;
    endcase
    if (w_bad) begin
      w_ctrl         = '0;
      w_ctrl.illegal = 1'b1;
    end
  end

  // Immediate assembly by format; R-type and illegal carry no immediate
  always_comb begin
    w_imm32 = '0;
    case (w_ctrl.instType)
      TYPE_I:  w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      TYPE_S:  w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      TYPE_B:  w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                          in_inst[30:25], in_inst[11:8], 1'b0};
      TYPE_U:  w_imm32 = {in_inst[31:12], 12'b0};
      TYPE_J:  w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                          in_inst[20], in_inst[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign w_entry.pc   = in_pc;
  assign w_entry.imm  = XLEN'($signed(w_imm32));
  assign w_entry.rs1  = in_inst[19:15];
  assign w_entry.rs2  = in_inst[24:20];
  assign w_entry.rd   = in_inst[11:7];
  assign w_entry.ctrl = w_ctrl;

  assign w_full    = (r_count == CNT_W'(BUF_DEPTH));
  assign in_ready  = r_live & ~w_full;
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;

  // FIFO pointers and occupancy; flush wins over push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_live   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Entry storage; contents are only visible while the slot is occupied
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  assign w_out = out_valid ? r_mem[r_rd_ptr] : '0;

  assign out_pc       = w_out.pc;
  assign out_imm      = w_out.imm;
  assign out_rs1      = w_out.rs1;
  assign out_rs2      = w_out.rs2;
  assign out_rd       = w_out.rd;
  assign out_instType = w_out.ctrl.instType;
  assign out_RegWrite = w_out.ctrl.RegWrite;
  assign out_MemRW    = w_out.ctrl.MemRW;
  assign out_MemWidth = w_out.ctrl.MemWidth;
  assign out_aluAsel  = w_out.ctrl.aluAsel;
  assign out_aluBsel  = w_out.ctrl.aluBsel;
  assign out_WBSel    = w_out.ctrl.WBSel;
  assign out_aluOp    = w_out.ctrl.aluOp;
  assign out_BrType   = w_out.ctrl.BrType;
  assign out_isBranch = w_out.ctrl.isBranch;
  assign out_isJump   = w_out.ctrl.isJump;
  assign out_BrUn     = w_out.ctrl.BrUn;
  assign out_ebreak   = w_out.ctrl.ebreak;
  assign out_illegal  = w_out.ctrl.illegal;

endmodule

// File: tb/tb_ysyx_23060061_decode_stage.sv
// Bench for ysyx_23060061_decode_stage: instruction-level decode model plus
// a queue model of the output buffer, checked every negative clock edge,
// with literal expectations for the hand-decoded instructions.
module tb_ysyx_23060061_decode_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int OUT_W = 105;

  localparam int T_R = 0, T_I = 1, T_S = 2, T_B = 3, T_U = 4, T_J = 5;
  // aluOp by funct3 for the base integer ops (add sll slt sltu xor srl or and)
  localparam int ALU_TAB [8] = '{0, 9, 5, 4, 6, 10, 7, 8};

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rs1, out_rs2, out_rd;
  logic [2:0]      out_instType;
  logic            out_RegWrite;
  logic [1:0]      out_MemRW;
  logic [2:0]      out_MemWidth;
  logic            out_aluAsel, out_aluBsel;
  logic [1:0]      out_WBSel;
  logic [4:0]      out_aluOp;
  logic [2:0]      out_BrType;
  logic            out_isBranch, out_isJump, out_BrUn, out_ebreak, out_illegal;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [OUT_W-1:0] exp_q[$];
  bit               m_live;
  logic [OUT_W-1:0] w_dut;

  ysyx_23060061_decode_stage #(.XLEN(XLEN), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_instType(out_instType), .out_RegWrite(out_RegWrite),
    .out_MemRW(out_MemRW), .out_MemWidth(out_MemWidth),
    .out_aluAsel(out_aluAsel), .out_aluBsel(out_aluBsel),
    .out_WBSel(out_WBSel), .out_aluOp(out_aluOp), .out_BrType(out_BrType),
    .out_isBranch(out_isBranch), .out_isJump(out_isJump), .out_BrUn(out_BrUn),
    .out_ebreak(out_ebreak), .out_illegal(out_illegal)
  );

  assign w_dut = {out_pc, out_imm, out_rs1, out_rs2, out_rd, out_instType,
                  out_RegWrite, out_MemRW, out_MemWidth, out_aluAsel,
                  out_aluBsel, out_WBSel, out_aluOp, out_BrType, out_isBranch,
                  out_isJump, out_BrUn, out_ebreak, out_illegal};

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- decode model (instruction semantics) ----------------
  function automatic logic [OUT_W-1:0] model_entry(input logic [31:0] inst,
                                                   input logic [31:0] pc);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int typ, alu, mrw, mw, wb, brt, imm;
    bit rw, asel, bsel, br, jmp, brun, ebrk, ok;
    op = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25];
    typ = T_R; alu = 0; mrw = 0; mw = 0; wb = 0; brt = 0; imm = 0;
    rw = 0; asel = 0; bsel = 0; br = 0; jmp = 0; brun = 0; ebrk = 0; ok = 1;
    if (op == 7'h37) begin
      typ = T_U; rw = 1; bsel = 1; alu = 1;
    end else if (op == 7'h17) begin
      typ = T_U; rw = 1; asel = 1; bsel = 1;
    end else if (op == 7'h6F) begin
      typ = T_J; rw = 1; jmp = 1; wb = 2; asel = 1; bsel = 1;
    end else if (op == 7'h67 && f3 == 0) begin
      typ = T_I; rw = 1; jmp = 1; wb = 2; alu = 2; bsel = 1;
    end else if (op == 7'h63 && f3 != 2 && f3 != 3) begin
      typ = T_B; br = 1; brt = f3; brun = (f3 == 6 || f3 == 7); asel = 1; bsel = 1;
    end else if (op == 7'h03 && (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) begin
      typ = T_I; rw = 1; mrw = 2; mw = f3; wb = 3; bsel = 1;
    end else if (op == 7'h23 && f3 <= 2) begin
      typ = T_S; mrw = 1; mw = f3; bsel = 1;
    end else if (op == 7'h13) begin
      if ((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20)) ok = 0;
      else begin
        typ = T_I; rw = 1; bsel = 1;
        alu = (f3 == 5 && f7 == 7'h20) ? 11 : ALU_TAB[f3];
      end
    end else if (op == 7'h33 && f7 == 0) begin
      typ = T_R; rw = 1; alu = ALU_TAB[f3];
    end else if (op == 7'h33 && f7 == 7'h20 && (f3 == 0 || f3 == 5)) begin
      typ = T_R; rw = 1; alu = (f3 == 0) ? 3 : 11;
`ifdef YSYX_23060061_RV32M_EN
    end else if (op == 7'h33 && f7 == 7'h01) begin
      typ = T_R; rw = 1; alu = 12 + f3; wb = 1;
`endif
    end else if (op == 7'h0F && f3 == 0) begin
      typ = T_I;
    end else if (inst == 32'h0000_0073) begin
      typ = T_I;
    end else if (inst == 32'h0010_0073) begin
      typ = T_I; ebrk = 1;
    end else begin
      ok = 0;
    end
    if (!ok) typ = T_R;
    case (typ)
      T_I: imm = $signed(inst[31:20]);
      T_S: imm = $signed({inst[31:25], inst[11:7]});
      T_B: begin imm = $signed({inst[31], inst[7], inst[30:25], inst[11:8]}); imm = imm * 2; end
      T_U: imm = int'(inst & 32'hFFFF_F000);
      T_J: begin imm = $signed({inst[31], inst[19:12], inst[20], inst[30:21]}); imm = imm * 2; end
      default: imm = 0;
    endcase
    return {pc, 32'(imm), inst[19:15], inst[24:20], inst[11:7], 3'(typ),
            rw, 2'(mrw), 3'(mw), asel, bsel, 2'(wb), 5'(alu), 3'(brt),
            br, jmp, brun, ebrk, !ok};
  endfunction

  // ---------------- buffer model ----------------
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_live = 0;
    end else begin
      bit push_ok, pop_ok;
      push_ok = m_live && in_valid && (exp_q.size() < DEPTH) && !flush;
      pop_ok  = (exp_q.size() > 0) && out_ready && !flush;
      if (flush) exp_q.delete();
      else begin
        if (pop_ok) void'(exp_q.pop_front());
        if (push_ok) exp_q.push_back(model_entry(in_inst, in_pc));
      end
      m_live = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_data", w_dut, '0);
    end else begin
      check("in_ready", in_ready, m_live && (exp_q.size() < DEPTH));
      check("out_valid", out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) check("head_entry", w_dut, exp_q[0]);
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single edge (caller guarantees space),
  // then stop on the following negative edge for literal checks.
  task automatic push_one(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  // Hold an instruction until it is accepted, bounded in cycles.
  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    bit acc;
    acc = 0;
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    for (int k = 0; k < 40 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    check("accept_bound", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  logic [31:0] vec [36] = '{
    32'h0050_0093, 32'hFE00_0EE3, 32'h1234_52B7, 32'h0000_1097,
    32'h0080_00EF, 32'hFFDF_F0EF, 32'h0000_80E7, 32'h0020_E063,
    32'h0020_F063, 32'h0020_C463, 32'h0040_A183, 32'h0000_C183,
    32'h0020_A423, 32'h0020_8023, 32'h0030_9093, 32'h4030_D093,
    32'h0010_B093, 32'hFFF0_0093, 32'h4020_81B3, 32'h4020_D1B3,
    32'h0020_F1B3, 32'h0020_91B3, 32'h0FF0_000F, 32'h0000_0073,
    32'h0010_0073, 32'hFFFF_FFFF, 32'h0000_B183, 32'h0020_B023,
    32'h0020_A063, 32'h0000_90E7, 32'h4020_91B3, 32'h4030_9093,
    32'h3000_1073, 32'h0220_81B3, 32'h0220_C1B3, 32'h0220_F1B3
  };

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_before_first_edge", in_ready, 1'b0);
    tick();
    @(negedge clk);
    check("ready_after_first_edge", in_ready, 1'b1);
    check("empty_after_reset", out_valid, 1'b0);
    tick();

    // addi x1,x0,5
    out_ready = 1'b1;
    push_one(32'h0050_0093, 32'h8000_0000);
    check("addi_valid", out_valid, 1'b1);
    check("addi_pc", out_pc, 32'h8000_0000);
    check("addi_rd", out_rd, 5'd1);
    check("addi_rs1", out_rs1, 5'd0);
    check("addi_imm", out_imm, 32'd5);
    check("addi_aluop", out_aluOp, 5'd0);
    check("addi_bsel", out_aluBsel, 1'b1);
    check("addi_regwrite", out_RegWrite, 1'b1);
    check("addi_illegal", out_illegal, 1'b0);
    tick();

    // beq x0,x0,-4
    push_one(32'hFE00_0EE3, 32'h8000_0004);
    check("beq_imm", out_imm, 32'hFFFF_FFFC);
    check("beq_isbranch", out_isBranch, 1'b1);
    check("beq_brtype", out_BrType, 3'b000);
    check("beq_brun", out_BrUn, 1'b0);
    check("beq_regwrite", out_RegWrite, 1'b0);
    tick();

    // lui x5,0x12345
    push_one(32'h1234_52B7, 32'h8000_0008);
    check("lui_imm", out_imm, 32'h1234_5000);
    check("lui_rd", out_rd, 5'd5);
    check("lui_aluop", out_aluOp, 5'd1);
    check("lui_type", out_instType, 3'd4);
    tick();

    // mul x3,x1,x2
    push_one(32'h0220_81B3, 32'h8000_000C);
`ifdef YSYX_23060061_RV32M_EN
    check("mul_aluop", out_aluOp, 5'd12);
    check("mul_illegal", out_illegal, 1'b0);
    check("mul_wbsel", out_WBSel, 2'b01);
`else
    check("mul_illegal", out_illegal, 1'b1);
    check("mul_regwrite", out_RegWrite, 1'b0);
    check("mul_aluop", out_aluOp, 5'd0);
`endif
    tick();

    // directed stream with a fixed backpressure pattern
    for (int i = 0; i < 36; i++) begin
      out_ready = (i % 3 != 2);
      send(vec[i], 32'h8000_1000 + 32'(i * 4));
    end
    out_ready = 1'b1;
    repeat (4) tick();

    // backpressure: fill, then drain with in_valid held, then flush
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h0040_A183; in_pc = 32'h0000_0100;
    tick();
    in_inst = 32'h0020_A423; in_pc = 32'h0000_0104;
    tick();
    in_inst = 32'h4020_81B3; in_pc = 32'h0000_0108;
    @(negedge clk);
    check("full_in_ready", in_ready, 1'b0);
    check("full_head_pc", out_pc, 32'h0000_0100);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_head_pc", out_pc, 32'h0000_0100);
    tick();
    @(negedge clk);
    check("drain1_pc", out_pc, 32'h0000_0104);
    check("drain1_ready", in_ready, 1'b1);
    tick();
    @(negedge clk);
    check("drain2_pc", out_pc, 32'h0000_0108);
    check("drain2_valid", out_valid, 1'b1);
    tick();
    in_inst = 32'h0010_0073; in_pc = 32'h0000_010C; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", out_valid, 1'b0);
    check("flush_ready", in_ready, 1'b1);
    tick();

    // asynchronous reset with two entries held
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h0000_0200;
    tick();
    in_pc = 32'h0000_0204;
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_ready", in_ready, 1'b0);
    check("async_rst_pc", out_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready0", in_ready, 1'b0);
    check("post_rst_empty", out_valid, 1'b0);
    tick();
    out_ready = 1'b1;
    push_one(32'h0050_0093, 32'h8000_0100);
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_pc", out_pc, 32'h8000_0100);
    check("post_rst_imm", out_imm, 32'd5);
    check("post_rst_rd", out_rd, 5'd1);
    tick();
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
